// File: rtl/action_executor.sv
// action_executor: runs flow-value action instructions against a packet header; define ACTION_STATS_EN for hit/miss/drop counters
module action_executor #(
    parameter int HDR_MAX_LEN = 64,
    parameter int NUM_HEADERS = 8,
    parameter int MAX_VAL_LEN = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     is_match_i,
    input  logic [MAX_VAL_LEN*8-1:0] flow_val_i,
    input  logic [HDR_MAX_LEN*8-1:0] pkt_hdr_i,
    input  logic [NUM_HEADERS*32-1:0] parsed_hdrs_i,
    input  logic                     mod_start_i,
    input  logic [7:0]               mod_default_port_i,
    input  logic                     mod_default_drop_i,
    output logic                     ready_o,
    output logic [HDR_MAX_LEN*8-1:0] pkt_hdr_o,
    output logic [7:0]               egress_port_o,
    output logic                     drop_o,
    output logic                     err_o
`ifdef ACTION_STATS_EN
    ,
    output logic [31:0]              hit_cnt_o,
    output logic [31:0]              miss_cnt_o,
    output logic [31:0]              drop_cnt_o
`endif
);
    localparam int SLOTS = MAX_VAL_LEN / 4;
    localparam int PW = SLOTS > 1 ? $clog2(SLOTS) : 1;
    localparam int AW = HDR_MAX_LEN > 1 ? $clog2(HDR_MAX_LEN) : 1;
    localparam int HW = NUM_HEADERS > 1 ? $clog2(NUM_HEADERS) : 1;

    typedef enum logic {IDLE, EXEC} state_t;
    state_t state, state_n;

    logic [HDR_MAX_LEN*8-1:0] work, work_n;
    logic [MAX_VAL_LEN*8-1:0] fv;
    logic [NUM_HEADERS*32-1:0] ph;
    logic [PW-1:0] pc;
    logic [7:0] port, port_n, def_port;
    logic err, err_n, drop_n, def_drop;
    logic [31:0] ins, base, addr;
    logic [7:0] op, hid, off, opd, cur;
    logic hid_ok, byte_op, fault, term;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    // decode current slot, compute its effect on the work buffer and the next state
    always_comb begin
        ins = fv[pc*32 +: 32];
        op = ins[7:0];
        hid = ins[15:8];
        off = ins[23:16];
        opd = ins[31:24];
        hid_ok = {24'b0, hid} < 32'(NUM_HEADERS);
        base = hid_ok ? ph[hid[HW-1:0]*32 +: 32] : 32'b0;
        addr = base + {24'b0, off};
        byte_op = op == 8'h01 || op == 8'h02 || op == 8'h03;
        fault = byte_op && (!hid_ok || addr >= 32'(HDR_MAX_LEN));
        cur = work[addr[AW-1:0]*8 +: 8];
        work_n = work;
        if (byte_op && !fault)
            work_n[addr[AW-1:0]*8 +: 8] = op == 8'h01 ? opd : op == 8'h02 ? cur + opd : cur - opd;
        port_n = op == 8'h04 ? opd : port;
        drop_n = op == 8'h05;
        err_n = err | fault | (op > 8'h05);
        term = op == 8'h00 || op >= 8'h05 || pc == PW'(SLOTS - 1);
        state_n = state == IDLE ? ((start_i && is_match_i && !mod_start_i) ? EXEC : IDLE)
                                : (term ? IDLE : EXEC);
    end

    // config, packet capture, per-slot execution and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_o <= 1'b0;
            pkt_hdr_o <= '0;
            egress_port_o <= 8'b0;
            drop_o <= 1'b0;
            err_o <= 1'b0;
            def_port <= 8'b0;
            def_drop <= 1'b0;
            work <= '0;
            fv <= '0;
            ph <= '0;
            pc <= '0;
            port <= 8'b0;
            err <= 1'b0;
`ifdef ACTION_STATS_EN
            hit_cnt_o <= 32'b0;
            miss_cnt_o <= 32'b0;
            drop_cnt_o <= 32'b0;
`endif
        end else begin
            ready_o <= 1'b0;
            if (state == IDLE) begin
                if (mod_start_i) begin
                    def_port <= mod_default_port_i;
                    def_drop <= mod_default_drop_i;
                end else if (start_i && !is_match_i) begin
                    pkt_hdr_o <= pkt_hdr_i;
                    egress_port_o <= def_port;
                    drop_o <= def_drop;
                    err_o <= 1'b0;
                    ready_o <= 1'b1;
`ifdef ACTION_STATS_EN
                    miss_cnt_o <= miss_cnt_o + 32'd1;
                    drop_cnt_o <= drop_cnt_o + 32'(def_drop);
`endif
                end else if (start_i) begin
                    work <= pkt_hdr_i;
                    fv <= flow_val_i;
                    ph <= parsed_hdrs_i;
                    pc <= '0;
                    port <= def_port;
                    err <= 1'b0;
                end
            end else begin
                work <= work_n;
                port <= port_n;
                err <= err_n;
                pc <= pc + 1'b1;
                if (term) begin
                    pkt_hdr_o <= work_n;
                    egress_port_o <= port_n;
                    drop_o <= drop_n;
                    err_o <= err_n;
                    ready_o <= 1'b1;
`ifdef ACTION_STATS_EN
                    hit_cnt_o <= hit_cnt_o + 32'd1;
                    drop_cnt_o <= drop_cnt_o + 32'(drop_n);
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_action_executor.sv
// tb_action_executor: randomized scoreboard bench for action_executor against a slot-by-slot reference model
module tb_action_executor;
    localparam int HDR = 64;
    localparam int NH = 8;
    localparam int VL = 16;
    localparam int SLOTS = VL / 4;
    localparam int HB = HDR * 8;
    localparam int FW = VL * 8;
    localparam int PB = NH * 32;

    logic clk = 0, rst = 1;
    logic start_i = 0, is_match_i = 0, mod_start_i = 0, mod_default_drop_i = 0;
    logic [FW-1:0] flow_val_i = '0;
    logic [HB-1:0] pkt_hdr_i = '0;
    logic [PB-1:0] parsed_hdrs_i = '0;
    logic [7:0] mod_default_port_i = 0;
    logic ready_o, drop_o, err_o;
    logic [HB-1:0] pkt_hdr_o;
    logic [7:0] egress_port_o;
`ifdef ACTION_STATS_EN
    logic [31:0] hit_cnt_o, miss_cnt_o, drop_cnt_o;
`endif

    action_executor dut (
        .clk(clk), .rst(rst), .start_i(start_i), .is_match_i(is_match_i),
        .flow_val_i(flow_val_i), .pkt_hdr_i(pkt_hdr_i), .parsed_hdrs_i(parsed_hdrs_i),
        .mod_start_i(mod_start_i), .mod_default_port_i(mod_default_port_i),
        .mod_default_drop_i(mod_default_drop_i), .ready_o(ready_o), .pkt_hdr_o(pkt_hdr_o),
        .egress_port_o(egress_port_o), .drop_o(drop_o), .err_o(err_o)
`ifdef ACTION_STATS_EN
        , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o), .drop_cnt_o(drop_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [HB-1:0] hdr;
        logic [7:0] port;
        logic drop;
        logic err;
        int lat;
        int due;
    } exp_t;

    exp_t q[$];
    int cyc = 0, checks = 0, errors = 0, issued = 0, popped = 0;
    logic [7:0] dp = 0;
    logic dd = 0;

    always @(posedge clk) cyc++;

    function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] id, input logic [7:0] off, input logic [7:0] opd);
        return {opd, off, id, op};
    endfunction

    // reference: walk the instruction list with a byte array, stopping at the first terminator
    function automatic exp_t model(input logic m, input logic [FW-1:0] f, input logic [HB-1:0] h, input logic [PB-1:0] p);
        exp_t e;
        logic [7:0] b [HDR];
        logic [7:0] op, id, off, opd;
        logic [31:0] a;
        int k;
        for (int i = 0; i < HDR; i++) b[i] = h[8*i +: 8];
        e.port = dp;
        e.drop = m ? 1'b0 : dd;
        e.err = 0;
        k = 0;
        if (m) begin
            for (int s = 0; s < SLOTS; s++) begin
                op = f[32*s +: 8];
                id = f[32*s+8 +: 8];
                off = f[32*s+16 +: 8];
                opd = f[32*s+24 +: 8];
                k = s + 1;
                if (op == 0) break;
                if (op == 4) e.port = opd;
                else if (op == 5) begin e.drop = 1; break; end
                else if (op > 5) begin e.err = 1; break; end
                else if (int'(id) >= NH) e.err = 1;
                else begin
                    a = p[32*int'(id) +: 32] + 32'(off);
                    if (a >= 32'(HDR)) e.err = 1;
                    else b[a] = op == 1 ? opd : op == 2 ? b[a] + opd : b[a] - opd;
                end
            end
        end
        for (int i = 0; i < HDR; i++) e.hdr[8*i +: 8] = b[i];
        e.lat = m ? k + 1 : 1;
        return e;
    endfunction

    task automatic chk(input string name, input logic [HB-1:0] act, input logic [HB-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // monitor: every ready_o pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && ready_o) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got ready at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("hdr", pkt_hdr_o, e.hdr);
                chk("port", HB'(egress_port_o), HB'(e.port));
                chk("drop", HB'(drop_o), HB'(e.drop));
                chk("err", HB'(err_o), HB'(e.err));
                chk("latency", HB'(cyc), HB'(e.due));
                popped++;
            end
        end
    end

    task automatic cfg(input logic [7:0] port, input logic drop);
        mod_start_i = 1;
        mod_default_port_i = port;
        mod_default_drop_i = drop;
        @(posedge clk);
        #1 mod_start_i = 0;
        dp = port;
        dd = drop;
    endtask

    task automatic issue(input logic m, input logic [FW-1:0] f, input logic [HB-1:0] h, input logic [PB-1:0] p);
        exp_t e;
        e = model(m, f, h, p);
        e.due = cyc + e.lat;
        q.push_back(e);
        issued++;
        start_i = 1;
        is_match_i = m;
        flow_val_i = f;
        pkt_hdr_i = h;
        parsed_hdrs_i = p;
        @(posedge clk);
        #1 start_i = 0;
        for (int i = 0; i < 20 && popped < issued; i++) @(posedge clk);
        if (popped < issued) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no ready_o expected one within 20 cycles");
            q.delete();
            popped = issued;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FW-1:0] rnd_flow();
        logic [FW-1:0] f;
        int r;
        logic [7:0] op;
        for (int s = 0; s < SLOTS; s++) begin
            r = $urandom_range(0, 15);
            op = r < 4 ? 8'd1 : r < 7 ? 8'd2 : r < 10 ? 8'd3 : r < 12 ? 8'd4 :
                 r < 13 ? 8'd0 : r < 14 ? 8'd5 : r < 15 ? 8'($urandom_range(6, 255)) : 8'd2;
            f[32*s +: 32] = ins(op, 8'($urandom_range(0, 9)), 8'($urandom_range(0, 40)), 8'($urandom));
        end
        return f;
    endfunction

    logic [HB-1:0] h;
    logic [PB-1:0] p;
    logic [FW-1:0] f;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset_ready", HB'(ready_o), '0);
        chk("reset_hdr", pkt_hdr_o, '0);
        chk("reset_port", HB'(egress_port_o), '0);
        chk("reset_flags", HB'({drop_o, err_o}), '0);
        @(posedge clk);
        #1;

        cfg(8'd3, 1'b0);
        h = '0;
        h[20*8 +: 8] = 8'h40;
        issue(1'b0, '0, h, '0);

        h = '0;
        h[22*8 +: 8] = 8'h40;
        p = '0;
        p[32 +: 32] = 32'd14;
        f = {32'h0, 32'h0, ins(8'h04, 8'h00, 8'h00, 8'h07), ins(8'h03, 8'h01, 8'h08, 8'h01)};
        issue(1'b1, f, h, p);

        h = '0;
        h[6*8 +: 8] = 8'hF8;
        p = '0;
        f = {32'h0, 32'h0, ins(8'h02, 8'h00, 8'h06, 8'h10), ins(8'h03, 8'h00, 8'h05, 8'h01)};
        issue(1'b1, f, h, p);

        f = {32'h0, 32'h0, ins(8'h04, 8'h00, 8'h00, 8'h09), ins(8'h05, 8'h00, 8'h00, 8'h00)};
        issue(1'b1, f, h, p);

        f = {32'h0, 32'h0, ins(8'h01, 8'h00, 8'h00, 8'hAA), ins(8'h01, 8'h09, 8'h00, 8'h55)};
        issue(1'b1, f, h, p);

        f = {32'h0, ins(8'h01, 8'h00, 8'h01, 8'h11), ins(8'h7E, 8'h00, 8'h00, 8'h00), ins(8'h04, 8'h00, 8'h00, 8'h02)};
        issue(1'b1, f, h, p);

        p[64 +: 32] = 32'd60;
        f = {ins(8'h02, 8'h00, 8'h03, 8'h01), ins(8'h02, 8'h00, 8'h03, 8'h05),
             ins(8'h01, 8'h02, 8'h04, 8'h33), ins(8'h01, 8'h02, 8'h03, 8'h22)};
        issue(1'b1, f, h, p);

        cfg(8'd5, 1'b1);
        issue(1'b0, '0, h, p);

        start_i = 1;
        is_match_i = 1;
        @(posedge clk);
        #1 start_i = 0;
        @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        dp = 0;
        dd = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_ready", HB'(ready_o), '0);
        end
        chk("abort_hdr", pkt_hdr_o, '0);
        chk("abort_port", HB'(egress_port_o), '0);
        chk("abort_flags", HB'({drop_o, err_o}), '0);
        @(posedge clk);
        #1;
        issue(1'b1, f, h, p);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) cfg(8'($urandom), 1'($urandom));
            for (int i = 0; i < HB / 32; i++) h[32*i +: 32] = $urandom;
            for (int i = 0; i < NH; i++) p[32*i +: 32] = 32'($urandom_range(0, 70));
            if ($urandom_range(0, 3) == 0) p[32*7 +: 32] = 32'hFFFF_FFF0;
            issue($urandom_range(0, 3) != 0, rnd_flow(), h, p);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/action_executor.md
Name: action_executor

Overview:
- Pipeline stage directly downstream of the flow matcher. Consumes its result: the ready pulse, the match flag and the flow value bytes.
- On a hit, interprets the flow value as a list of 4-byte action instructions and executes one instruction per cycle against a working copy of the packet header.
- On a miss, applies a configurable default action.
- Emits the modified header, egress port and drop decision to the deparser/output stage.

Parameters:
- HDR_MAX_LEN, 64, bytes in packet header buffer
- NUM_HEADERS, 8, entries in parsed header offset table
- MAX_VAL_LEN, 16, flow value bytes; must be a multiple of 4; instruction slots = MAX_VAL_LEN/4

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_i  in  1  matcher result valid; one-cycle pulse
- is_match_i  in  1  matcher hit flag
- flow_val_i  in  8 x MAX_VAL_LEN  flow value bytes; instruction i occupies bytes 4i..4i+3 as {opcode, hdr_id, offset, operand}
- pkt_hdr_i  in  8 x HDR_MAX_LEN  packet header bytes
- parsed_hdrs_i  in  32 x NUM_HEADERS  byte offset of each parsed header
- mod_start_i  in  1  config write strobe
- mod_default_port_i  in  8  egress port used on a miss and as the initial port on a hit
- mod_default_drop_i  in  1  drop on a miss
- ready_o  out  1  result valid; one-cycle pulse
- pkt_hdr_o  out  8 x HDR_MAX_LEN  modified header
- egress_port_o  out  8  egress port
- drop_o  out  1  drop decision
- err_o  out  1  at least one instruction faulted for this packet

Behaviour:
- Reset: all outputs 0, pkt_hdr_o all bytes 0, default_port 0, default_drop 0, state IDLE.
  - Reset mid-EXEC aborts the packet and produces no ready_o.
- States: IDLE, EXEC.
- IDLE, mod_start_i=1: latch both config fields. A simultaneous start_i is ignored; the upstream stage must not issue both together.
- IDLE, start_i=1, is_match_i=0 (miss):
  - Register pkt_hdr_o <= pkt_hdr_i unmodified, egress_port_o <= default_port, drop_o <= default_drop, err_o <= 0, ready_o <= 1.
  - Stay in IDLE. Latency 1 cycle.
- IDLE, start_i=1, is_match_i=1 (hit):
  - Latch pkt_hdr_i into the work buffer. Latch flow_val_i and parsed_hdrs_i.
  - Set pc=0, port=default_port, drop=0, err=0. Go to EXEC.
- EXEC: execute slot pc each cycle.
  - addr = parsed_hdrs[hdr_id] + offset, computed in 32 bits.
  - Fault when hdr_id >= NUM_HEADERS or addr >= HDR_MAX_LEN. A faulting byte op performs no write, sets err, and execution continues.
  - 0x00 END: terminate.
  - 0x01 SET: buf[addr] = operand.
  - 0x02 ADD: buf[addr] = buf[addr] + operand, mod 256.
  - 0x03 SUB: buf[addr] = buf[addr] - operand, mod 256.
  - 0x04 FWD: port = operand. Multiple FWDs: the last one wins.
  - 0x05 DROP: drop=1, terminate.
  - Other opcodes: set err, terminate.
  - Slot pc = MAX_VAL_LEN/4 - 1 executes normally, then terminates.
- Terminating cycle:
  - The register update includes that instruction's own effect, i.e. buffer writes are visible in pkt_hdr_o.
  - Register pkt_hdr_o <= buffer, egress_port_o, drop_o, err_o, ready_o <= 1. Return to IDLE.
- Hit latency: ready_o goes high k+1 cycles after start_i is sampled, where k = instructions executed including the terminator.
- Two ops on the same byte in consecutive slots see each other's result, because the buffer updates each cycle.
- ready_o is high for exactly 1 cycle. All other outputs hold until the next result.
- start_i during EXEC is ignored; upstream guarantees spacing.
- mod_start_i during EXEC is ignored.

Optional Feature:
- ACTION_STATS_EN defined: adds ports hit_cnt_o, miss_cnt_o and drop_cnt_o, each 32-bit.
  - Each counter increments in the cycle ready_o is registered: hit_cnt_o on a hit, miss_cnt_o on a miss, drop_cnt_o whenever the registered drop_o is 1.
  - Counters wrap at 2^32 and reset to 0.
- ACTION_STATS_EN undefined: these ports and counters are absent. All other behaviour is identical.

Test Plan:
- Config default_port=3, default_drop=0; miss with pkt_hdr_i[20]=0x40 -> ready_o 1 cycle after start, pkt_hdr_o[20]=0x40, egress_port_o=3, drop_o=0, err_o=0.
- Hit with parsed_hdrs[1]=14, flow {03,01,08,01 | 04,00,00,07 | 00...}, byte 22=0x40 (TTL decrement) -> ready_o 4 cycles after start (k=3), pkt_hdr_o[22]=0x3F, egress_port_o=7.
- Hit with SUB operand 1 on byte value 0x00 -> byte becomes 0xFF (wrap); ADD 0x10 on 0xF8 -> 0x08.
- Hit {05,..|04,00,00,09} -> drop_o=1, ready_o after k=1, egress_port_o=default_port (the FWD after DROP is not executed).
- Hit SET with hdr_id=9 followed by SET of byte 0 to 0xAA, then END -> err_o=1, pkt_hdr_o[0]=0xAA; opcode 0x7E -> err_o=1, terminates at that slot.
- Four non-END slots -> terminates after slot 3 (ready_o k=4). Assert rst during EXEC -> no ready_o, all outputs 0; the next start is processed normally.
